// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM bus arbiter.
// Bus request fields travel as one packed struct so the bus register is loaded in one step.
package sram_bus_arbiter_pkg;

  localparam int RegBus  = 32;
  localparam int StallPc = 0;
  localparam int StallEx = 3;
  localparam logic [3:0] BusSelAll = 4'b1111;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbMem  = 2'd1,
    ArbIf   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [RegBus-1:0] addr;
    logic [3:0]        sel;
    logic [RegBus-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/sram_bus_arbiter_bus_req_slot.sv
// Per-requester result slot: done/discard flags plus data buffer, updated on transfer end.
// Holds a result until the pipeline advances; a flush drops it, including one still in flight.
module bus_req_slot
  import sram_bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance_i,
  input  logic              flush_i,
  input  logic              busy_i,
  input  logic              end_i,
  input  logic              capture_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic              done_o,
  output logic [RegBus-1:0] data_o
);

  logic              done_q, done_d;
  logic              discard_q, discard_d;
  logic [RegBus-1:0] buf_q, buf_d;

  always_comb begin
    done_d    = done_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    if (advance_i || flush_i) begin
      done_d = 1'b0;
    end
    // A flush landing on the final transfer cycle must also drop that result.
    if (end_i && !discard_q && !flush_i) begin
      done_d = 1'b1;
    end
    if (end_i) begin
      discard_d = 1'b0;
    end else if (flush_i && busy_i) begin
      discard_d = 1'b1;
    end
    if (end_i && capture_i) begin
      buf_d = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      discard_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      done_q    <= done_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
    end
  end

  assign done_o = done_q;
  assign data_o = done_q ? buf_q : '0;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one 32-bit SRAM bus between fetch and data requesters, data first; 2-cycle min latency.
// Requesters stall via *_stallreq_o until their result is done; a transfer times out after TIMEOUT_CYCLES.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [RegBus-1:0] if_addr_i,
  output logic [RegBus-1:0] if_data_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [RegBus-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [RegBus-1:0] mem_data_i,
  output logic [RegBus-1:0] mem_data_o,
  output logic              mem_stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [RegBus-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [RegBus-1:0] bus_data_o,
  input  logic [RegBus-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  bus_req_t          req_q, req_d;
  logic              err_q, err_d;

  logic              done_if, done_mem;
  logic              pend_if, pend_mem;
  logic              xfer_end;
  logic [RegBus-1:0] rdata;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5:4], stall_i[2:1]};

  assign pend_if        = if_ce_i & ~done_if;
  assign pend_mem       = mem_ce_i & ~done_mem;
  assign if_stallreq_o  = pend_if;
  assign mem_stallreq_o = pend_mem;

  assign xfer_end = (state_q != ArbIdle) &&
                    (bus_ack_i || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)));
  assign rdata    = bus_ack_i ? bus_data_i : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cyc_d   = cyc_q;
    req_d   = req_q;
    err_d   = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (pend_mem) begin
          state_d    = ArbMem;
          cyc_d      = 1'b1;
          req_d.we   = mem_we_i;
          req_d.addr = mem_addr_i;
          req_d.sel  = mem_sel_i;
          req_d.data = mem_data_i;
        end else if (pend_if) begin
          state_d    = ArbIf;
          cyc_d      = 1'b1;
          req_d.we   = 1'b0;
          req_d.addr = if_addr_i;
          req_d.sel  = BusSelAll;
          req_d.data = '0;
        end
      end
      ArbMem, ArbIf: begin
        if (xfer_end) begin
          state_d = ArbIdle;
          cyc_d   = 1'b0;
          req_d   = '0;
          err_d   = ~bus_ack_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ArbIdle;
        cyc_d   = 1'b0;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  bus_req_slot u_if_slot (
    .clk       (clk),
    .rst       (rst),
    .advance_i (~stall_i[StallPc]),
    .flush_i   (flush_i),
    .busy_i    (state_q == ArbIf),
    .end_i     (xfer_end && (state_q == ArbIf)),
    .capture_i (1'b1),
    .rdata_i   (rdata),
    .done_o    (done_if),
    .data_o    (if_data_o)
  );

  // Stores leave the load buffer untouched.
  bus_req_slot u_mem_slot (
    .clk       (clk),
    .rst       (rst),
    .advance_i (~stall_i[StallEx]),
    .flush_i   (flush_i),
    .busy_i    (state_q == ArbMem),
    .end_i     (xfer_end && (state_q == ArbMem)),
    .capture_i (~req_q.we),
    .rdata_i   (rdata),
    .done_o    (done_mem),
    .data_o    (mem_data_o)
  );

  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = cyc_q;
  assign bus_we_o   = req_q.we;
  assign bus_addr_o = req_q.addr;
  assign bus_sel_o  = req_q.sel;
  assign bus_data_o = req_q.data;
  assign bus_err_o  = err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: fetch, priority, store, timeout, flush and reset scenarios.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  sram_bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_stallreq_o  (if_stallreq_o),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_sel_i      (mem_sel_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .mem_stallreq_o (mem_stallreq_o),
    .bus_cyc_o      (bus_cyc_o),
    .bus_stb_o      (bus_stb_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_sel_o      (bus_sel_o),
    .bus_data_o     (bus_data_o),
    .bus_data_i     (bus_data_i),
    .bus_ack_i      (bus_ack_i),
    .bus_err_o      (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall_i    = 6'b000000;
    flush_i    = 1'b0;
    if_ce_i    = 1'b0;
    if_addr_i  = 32'h0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0;
    mem_sel_i  = 4'h0;
    mem_data_i = 32'h0;
    bus_data_i = 32'h0;
    bus_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_cyc", {31'b0, bus_cyc_o}, 32'h0);
    check("rst_stb", {31'b0, bus_stb_o}, 32'h0);
    check("rst_err", {31'b0, bus_err_o}, 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_if_data", if_data_o, 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    check("rst_if_stall", {31'b0, if_stallreq_o}, 32'h0);
    rst = 1'b0;

    // Store with partial byte enables
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300;
    mem_sel_i = 4'b0011; mem_data_i = 32'hDEAD_BEEF; stall_i = 6'b011111;
    #1;
    check("st_stallreq_comb", {31'b0, mem_stallreq_o}, 32'h1);
    tick();
    check("st_cyc", {31'b0, bus_cyc_o}, 32'h1);
    check("st_we", {31'b0, bus_we_o}, 32'h1);
    check("st_sel", {28'b0, bus_sel_o}, 32'h3);
    check("st_addr", bus_addr_o, 32'h300);
    tick();
    check("st_data_held", bus_data_o, 32'hDEAD_BEEF);
    check("st_cyc_held", {31'b0, bus_cyc_o}, 32'h1);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    check("st_cyc_drop", {31'b0, bus_cyc_o}, 32'h0);
    check("st_stallreq_done", {31'b0, mem_stallreq_o}, 32'h0);
    check("st_mem_data", mem_data_o, 32'h0);
    stall_i = 6'b000000;
    tick();
    check("st_done_cleared", {31'b0, mem_stallreq_o}, 32'h1);
    mem_ce_i = 1'b0;
    do_reset();

    // Fetch only, ack in the first transfer cycle
    if_ce_i = 1'b1; if_addr_i = 32'h100; stall_i = 6'b000011;
    #1;
    check("f_stallreq_c0", {31'b0, if_stallreq_o}, 32'h1);
    tick();
    check("f_stallreq_c1", {31'b0, if_stallreq_o}, 32'h1);
    check("f_cyc", {31'b0, bus_cyc_o}, 32'h1);
    check("f_addr", bus_addr_o, 32'h100);
    check("f_sel", {28'b0, bus_sel_o}, 32'hF);
    check("f_we", {31'b0, bus_we_o}, 32'h0);
    bus_ack_i = 1'b1; bus_data_i = 32'h3401_0020;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("f_stallreq_done", {31'b0, if_stallreq_o}, 32'h0);
    check("f_if_data", if_data_o, 32'h3401_0020);
    check("f_cyc_drop", {31'b0, bus_cyc_o}, 32'h0);
    stall_i = 6'b000000; if_ce_i = 1'b0;
    tick();
    check("f_if_data_cleared", if_data_o, 32'h0);
    do_reset();

    // Simultaneous requests: data first, then fetch after an idle cycle
    if_ce_i = 1'b1; if_addr_i = 32'h100;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'hF;
    stall_i = 6'b001111;
    tick();
    check("p_addr_mem", bus_addr_o, 32'h200);
    check("p_both_stall", {30'b0, if_stallreq_o, mem_stallreq_o}, 32'h3);
    bus_ack_i = 1'b1; bus_data_i = 32'h1111_2222;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("p_idle_gap", {31'b0, bus_cyc_o}, 32'h0);
    check("p_stall_order", {30'b0, if_stallreq_o, mem_stallreq_o}, 32'h2);
    check("p_mem_data", mem_data_o, 32'h1111_2222);
    tick();
    check("p_addr_if", bus_addr_o, 32'h100);
    check("p_cyc_if", {31'b0, bus_cyc_o}, 32'h1);
    bus_ack_i = 1'b1; bus_data_i = 32'h5555_6666;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("p_stall_none", {30'b0, if_stallreq_o, mem_stallreq_o}, 32'h0);
    check("p_if_data", if_data_o, 32'h5555_6666);
    check("p_mem_data_kept", mem_data_o, 32'h1111_2222);
    do_reset();

    // No ack: 16 transfer cycles then forced termination
    if_ce_i = 1'b1; if_addr_i = 32'h400; stall_i = 6'b000011;
    repeat (16) tick();
    check("t_cyc_last", {31'b0, bus_cyc_o}, 32'h1);
    check("t_err_early", {31'b0, bus_err_o}, 32'h0);
    tick();
    check("t_cyc_drop", {31'b0, bus_cyc_o}, 32'h0);
    check("t_err_pulse", {31'b0, bus_err_o}, 32'h1);
    check("t_if_data", if_data_o, 32'h0);
    check("t_stallreq", {31'b0, if_stallreq_o}, 32'h0);
    tick();
    check("t_err_one_cycle", {31'b0, bus_err_o}, 32'h0);
    do_reset();

    // Flush during a fetch transfer: old result dropped, new address fetched
    if_ce_i = 1'b1; if_addr_i = 32'h500; stall_i = 6'b000011;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    if_addr_i = 32'h600;
    check("fl_addr_held", bus_addr_o, 32'h500);
    bus_ack_i = 1'b1; bus_data_i = 32'hBADB_AD00;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("fl_stall_kept", {31'b0, if_stallreq_o}, 32'h1);
    check("fl_old_dropped", if_data_o, 32'h0);
    tick();
    check("fl_new_addr", bus_addr_o, 32'h600);
    bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("fl_new_data", if_data_o, 32'h1234_5678);
    check("fl_stall_done", {31'b0, if_stallreq_o}, 32'h0);
    do_reset();

    // Reset in the middle of a data transfer with a fetch result held
    if_ce_i = 1'b1; if_addr_i = 32'h100; stall_i = 6'b001111;
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'hAAAA_5555;
    tick();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    check("r_if_data", if_data_o, 32'hAAAA_5555);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h700; mem_sel_i = 4'hF;
    tick();
    check("r_mem_cyc", {31'b0, bus_cyc_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_cyc_drop", {31'b0, bus_cyc_o}, 32'h0);
    check("r_addr_zero", bus_addr_o, 32'h0);
    check("r_if_data_cleared", if_data_o, 32'h0);
    check("r_stallreqs", {30'b0, if_stallreq_o, mem_stallreq_o}, 32'h3);
    tick();
    check("r_restart_addr", bus_addr_o, 32'h700);
    check("r_restart_cyc", {31'b0, bus_cyc_o}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
